// File: rtl/serial_word_rx.sv
// Serial-to-parallel frame receiver: start-bit detect, mid-bit sampling, stop-bit check, valid/ready word output.
// Optional even-parity bit after the data bits is enabled by defining SERIAL_WORD_RX_PARITY_EN.
module serial_word_rx #(
    parameter int M   = 8,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_in,
    input  logic         ready,
    output logic [M-1:0] byte_out,
    output logic         valid,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun,
    output logic         busy
);
    localparam int H   = DIV / 2;
    localparam int TW  = $clog2(DIV + 1);
    localparam int BCW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef SERIAL_WORD_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t         state_q;
    logic [TW-1:0]  timer_q;
    logic [BCW-1:0] bit_cnt_q;
    logic [M-1:0]   shift_q;
    logic [M-1:0]   shift_d;
    logic [M-1:0]   byte_out_q;
    logic           valid_q;
    logic           frame_err_q;
    logic           overrun_q;
    logic           busy_q;
    logic           sample_s;
    logic           load_ok_s;
    logic           stop_good_s;

`ifdef SERIAL_WORD_RX_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;

    function automatic logic even_parity_bad(input logic [M-1:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction
`endif

    // Sample strobe, next shift-register value and word acceptance conditions.
    always_comb begin
        shift_d      = shift_q >> 1;
        shift_d[M-1] = bit_in;
        sample_s     = (timer_q == TW'(1));
        load_ok_s    = ~valid_q | ready;
`ifdef SERIAL_WORD_RX_PARITY_EN
        stop_good_s  = bit_in & ~par_bad_q;
`else
        stop_good_s  = bit_in;
`endif
    end

    // Receive FSM with bit timer, bit counter, shift register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_out_q   <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // A consumer accept clears valid unless a new word loads on the same edge below.
            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_q <= START;
                        timer_q <= TW'(H);
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (sample_s) begin
                        if (bit_in) begin
                            state_q <= IDLE;
                            timer_q <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            timer_q   <= TW'(DIV);
                            bit_cnt_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                DATA: begin
                    if (sample_s) begin
                        shift_q <= shift_d;
                        timer_q <= TW'(DIV);
                        if (bit_cnt_q == BCW'(M - 1)) begin
                            bit_cnt_q <= '0;
`ifdef SERIAL_WORD_RX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
`ifdef SERIAL_WORD_RX_PARITY_EN
                PARITY: begin
                    if (sample_s) begin
                        par_bad_q <= even_parity_bad(shift_q, bit_in);
                        timer_q   <= TW'(DIV);
                        state_q   <= STOP;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
`endif
                STOP: begin
                    if (sample_s) begin
                        timer_q <= '0;
`ifdef SERIAL_WORD_RX_PARITY_EN
                        parity_err_q <= par_bad_q;
                        par_bad_q    <= 1'b0;
`endif
                        if (!bit_in) begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                        // A pending unconsumed word wins; the new one is dropped and flagged.
                        if (stop_good_s) begin
                            if (load_ok_s) begin
                                byte_out_q <= shift_q;
                                valid_q    <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (bit_in) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_out  = byte_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
`ifdef SERIAL_WORD_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel frame receiver: the receive end of the team's serial word link, facing the parallel-in/serial-out transmitter. It detects a start bit on a single-wire line that idles high, samples M data bits LSB-first at mid-bit, and checks the stop bit. Each good word is presented on a parallel bus with a valid/ready handshake. It sits between the serial line and the consumer logic, replacing the bare serial-in shift register plus external triggers.

## Interface

- M, default 8: data bits per frame, ≥1.
- DIV, default 4: clock cycles per bit period, ≥2. H = DIV/2 (floor) is the mid-bit offset.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- bit_in  in  1  serial line, synchronous to clk; idle level 1.
- ready  in  1  consumer accepts byte_out on an edge where valid=1.
- byte_out  out  M  last received word, bit 0 = first data bit received.
- valid  out  1  byte_out holds an unconsumed word.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- parity_err  out  1  one-cycle pulse: parity mismatch. Tied 0 without the macro.
- overrun  out  1  sticky: a good word was dropped because valid was still pending.
- busy  out  1  1 in every state except IDLE.

## Operation

- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- IDLE: on an edge with bit_in=0 (cycle t0), load the bit-timer to H and go to START. busy rises after t0.
- Sample edges: t0+H+n·DIV. n=0 is the start bit, n=1..M are data bits, n=M+1 is parity (macro only), and the next index is the stop bit.
- START: if the sample is 1, treat it as a glitch and return to IDLE with no flags. If 0, go to DATA.
- DATA: shift the sample into the MSB of an internal M-bit shift register (right shift), so the first bit received ends up in bit 0. A bit counter counts 0..M-1; after the M-th sample go to PARITY or STOP.
- STOP, sample 1, no parity error: the word is good. If valid=0, or valid=1 and ready=1 on the same edge, load byte_out and set valid=1. Otherwise drop the word, keep byte_out, and set overrun. Then go to IDLE.
- STOP, sample 0: pulse frame_err, discard the word, go to WAIT_IDLE.
- WAIT_IDLE: stay until an edge with bit_in=1, then go to IDLE.
- Handshake: valid=1 and ready=1 on an edge clears valid, unless a new good word loads on that same edge; then valid stays 1 with the new data. ready while valid=0 is ignored. byte_out is stable while valid=1.
- overrun clears only on reset.
- bit_in is not synchronized internally. The upstream driver is responsible for clk-domain timing.

## Timing

- Reset (async assert, any state, mid-frame included): state IDLE, byte_out=0, valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, timers and shift register 0. A partial frame is lost.
- Reset deassertion is synchronized to clk by the integrator. The first start bit can be detected on the first edge after deassertion.
- Word latency: valid is high immediately after edge t0+H+(M+1)·DIV, or t0+H+(M+2)·DIV with parity. For M=8, DIV=4: t0+38 (t0+42 with parity).
- frame_err and parity_err are high for exactly the cycle after the stop/parity-check edge.
- busy falls after the stop edge when the frame is good, or after the WAIT_IDLE exit edge when it is not.
- Back-to-back frames: a new start can be detected on the first edge after the stop edge. No minimum idle time is required beyond that.

## Configuration

- SERIAL_WORD_RX_PARITY_EN defined: one even-parity bit follows the data bits. The PARITY state samples it. XOR of the M data bits and the parity bit must be 0.
  - On mismatch, parity_err pulses after the stop edge and the word is discarded.
  - A frame with both a parity mismatch and a bad stop bit pulses both flags and goes to WAIT_IDLE.
- Not defined: no parity bit in the frame, no PARITY state, parity_err constant 0.

## Test plan

- Reset mid-frame: reset=0 at t0+10 during word 0x5A (M=8, DIV=4) -> all outputs 0 during reset. After release, a clean 0x3C frame gives byte_out=0x3C, valid=1.
- Good frame, ready held 0: 0xA5 sent LSB-first (1,0,1,0,0,1,0,1) -> valid=1 exactly after edge t0+38, byte_out=0xA5. ready=1 for one cycle clears valid.
- Glitch: bit_in low for 1 cycle, then high -> no valid, no flags, busy=1 for H cycles then 0.
- Frame error: 0xFF frame with stop=0 -> frame_err high for 1 cycle, valid stays 0. FSM stays in WAIT_IDLE while line held 0 for 10 cycles, then detects a following 0x01 frame.
- Overrun and simultaneous accept: two back-to-back frames 0x11, 0x22.
  - ready=0 throughout -> byte_out=0x11, overrun=1.
  - Repeat with ready=1 only on the second frame's stop edge -> byte_out=0x22, valid=1, overrun=0.
- Parity (macro): 0x03 with parity 0 -> valid, byte_out=0x03. 0x03 with parity 1 -> parity_err pulse, no valid.
